fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction-fetch front end of the pipelined ARM core. It owns the program counter and drives the byte address into the instruction memory, whose read is combinational. It captures the returned instruction and its PC into the IF/ID pipeline register. It handles decode-stage stalls, taken-branch redirects, end-of-program halt and, optionally, fetch-address faults.

## Interface
Parameters:
- PC_WIDTH, 64, width of PC, branch target and imem address.
- INSTR_WIDTH, `INSTR_LEN (32), instruction width.
- RESET_PC, 0, PC value after reset.
- IMEM_SIZE, 1024, instruction memory depth in words; used only by the fault check.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- stall  in  1  hold PC and IF/ID (load-use hazard from decode).
- branch_taken  in  1  redirect fetch this cycle.
- branch_target  in  PC_WIDTH  byte address to redirect to.
- imem_addr  out  PC_WIDTH  byte address to instruction memory; memory indexes word imem_addr[..:2].
- imem_instr  in  INSTR_WIDTH  combinational read data for imem_addr.
- if_pc  out  PC_WIDTH  IF/ID: PC of the captured instruction.
- if_instr  out  INSTR_WIDTH  IF/ID: captured instruction.
- if_valid  out  1  IF/ID: entry holds a real instruction (0 = bubble).
- halted  out  1  fetch is in HALT state.
- fetch_fault  out  1  sticky fault flag (see Configuration).

## Operation
- The unit is the single clock domain on clk with asynchronous active-high reset.
- Reset values:
  - pc = RESET_PC, so imem_addr = RESET_PC.
  - if_pc = 0, if_instr = 32'hD503201F (NOP), if_valid = 0.
  - State = RUN, halted = 0, fetch_fault = 0.
- imem_addr = pc, driven combinationally from the register with no added logic.
- A bubble load sets if_valid = 0, if_instr = NOP and if_pc = current pc.
- States are RUN, HALT and FAULT. FAULT exists only with the macro.
- RUN, evaluated per edge with the first matching rule winning:
  1. branch_taken: pc <= branch_target; IF/ID <= bubble; stay in RUN. The in-flight wrong-path fetch is discarded.
  2. stall: pc and IF/ID hold; no state change. No halt or fault evaluation happens while stalled.
  3. Fault condition (macro only): FAULT; IF/ID <= bubble; pc holds.
  4. imem_instr == 0: HALT; IF/ID <= bubble; pc holds. The zero word is never forwarded.
  5. Otherwise: if_pc <= pc, if_instr <= imem_instr, if_valid <= 1, pc <= pc + 4.
- HALT:
  - halted = 1.
  - pc holds and IF/ID <= bubble every edge, regardless of stall.
  - branch_taken: pc <= branch_target, return to RUN, halted falls. This covers a halt triggered by a speculative fetch past program end.
- FAULT:
  - fetch_fault = 1 and halted = 0.
  - pc holds and IF/ID <= bubble every edge.
  - The state is exited only by reset; branch_taken is ignored.
- Arithmetic: pc + 4 is modulo 2^PC_WIDTH, with no carry out or overflow flag.

## Timing
- Fetch latency is 1 cycle. The instruction at pc appears on if_instr/if_valid after the next rising edge.
- Throughput is one instruction per cycle when there is no stall or branch.
- Branch: if branch_taken is asserted in cycle N, imem_addr = branch_target in cycle N+1. The target instruction is valid in IF/ID after the N+1 edge, giving exactly one bubble.
- Stall: IF/ID and imem_addr are unchanged on every edge where stall=1 and branch_taken=0.
- Simultaneous branch_taken and stall: the branch wins.
- Reset asserted mid-operation forces all reset values immediately, without waiting for an edge. The first fetch from RESET_PC is captured on the first edge after reset deasserts.

## Configuration
- FETCH_BOUNDS_CHECK_EN defined:
  - The fault condition is pc[1:0] != 0 or pc >= IMEM_SIZE*4.
  - It is evaluated in RUN at rule 3, so a bad branch_target faults on the cycle after the redirect.
- FETCH_BOUNDS_CHECK_EN undefined:
  - No check; FAULT is unreachable and fetch_fault is tied 0.
  - pc[1:0] is ignored by memory and out-of-range addresses alias modulo memory depth.

## Test plan
- Reset then run with words 1..3 at 0x0/0x4/0x8 -> if_pc 0x0, 0x4, 0x8 on consecutive edges with if_valid=1. Reset values checked before the first edge.
- stall high for 2 cycles while pc=0x8 -> imem_addr stays 0x8 and IF/ID holds the 0x4 entry; fetch resumes with 0x8 on release.
- branch_taken with target 0x40 and stall in the same cycle -> one bubble (if_valid=0, NOP), then if_pc=0x40 holding the 0x40 instruction.
- Zero word at 0xC -> halted=1, if_valid=0, pc holds 0xC. A later branch_taken to 0x0 -> halted=0, refetch from 0x0.
- With macro, branch to 0x42 -> next edge fetch_fault=1. Branch to 0x1000 with IMEM_SIZE=1024 -> fault. A subsequent branch does not clear it; reset does.
- Without macro, branch to 0x42 -> no fault and fetch proceeds from 0x42 (word 16), with fetch_fault constantly 0.

Source files
------------

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction-fetch front end: PC, imem address, IF/ID register
//
// Purpose: owns the program counter, drives imem_addr from it, and captures the
// combinationally read instruction plus its PC into the IF/ID register. It also
// handles decode stalls, taken-branch redirects, end-of-program halt and the
// optional fetch-address fault.
//
// Optional feature macro: FETCH_BOUNDS_CHECK_EN (enables the FAULT state).
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   stall                 hold PC and IF/ID
//   branch_taken          redirect fetch to branch_target
//   branch_target         redirect byte address
//   imem_addr             byte address to instruction memory (= pc)
//   imem_instr            combinational read data for imem_addr
//   if_pc, if_instr       IF/ID register contents
//   if_valid              IF/ID holds a real instruction
//   halted                fetch is in HALT
//   fetch_fault           sticky fetch-address fault

`ifndef INSTR_LEN
`define INSTR_LEN 32
`endif

module fetch_unit #(
   parameter int                   PC_WIDTH    = 64,
   parameter int                   INSTR_WIDTH = `INSTR_LEN,
   parameter logic [PC_WIDTH-1:0]  RESET_PC    = '0,
   parameter int                   IMEM_SIZE   = 1024
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   stall,
   input  logic                   branch_taken,
   input  logic [PC_WIDTH-1:0]    branch_target,
   output logic [PC_WIDTH-1:0]    imem_addr,
   input  logic [INSTR_WIDTH-1:0] imem_instr,
   output logic [PC_WIDTH-1:0]    if_pc,
   output logic [INSTR_WIDTH-1:0] if_instr,
   output logic                   if_valid,
   output logic                   halted,
   output logic                   fetch_fault
);

   localparam logic [INSTR_WIDTH-1:0] NOP        = INSTR_WIDTH'(32'hD503201F);
   localparam logic [PC_WIDTH-1:0]    IMEM_BYTES = PC_WIDTH'(IMEM_SIZE) << 2;

`ifdef FETCH_BOUNDS_CHECK_EN
   localparam bit CHECK_EN = 1'b1;
`else
   localparam bit CHECK_EN = 1'b0;
`endif

   typedef enum logic [1:0] {
      S_RUN   = 2'd0,
      S_HALT  = 2'd1,
      S_FAULT = 2'd2
   } state_t;

   state_t              state;
   state_t              state_next;
   logic [PC_WIDTH-1:0] pc;
   logic [PC_WIDTH-1:0] pc_next;
   logic                load_fetch;
   logic                load_bubble;
   logic                addr_bad;

   assign imem_addr = pc;

   // Misaligned or beyond the end of instruction memory.
   assign addr_bad = CHECK_EN && ((pc[1:0] != 2'b00) || (pc >= IMEM_BYTES));

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= S_RUN;
      end else begin
         state <= state_next;
      end
   end

   // Next-state and datapath control. When neither load is set, IF/ID holds.
   always_comb begin
      state_next  = state;
      pc_next     = pc;
      load_fetch  = 1'b0;
      load_bubble = 1'b0;
      case (state)
         S_RUN: begin
            if (branch_taken) begin
               // The wrong-path word currently on imem_instr is dropped.
               pc_next     = branch_target;
               load_bubble = 1'b1;
            end else if (stall) begin
               // Hold everything; halt/fault are not evaluated while stalled.
            end else if (addr_bad) begin
               state_next  = S_FAULT;
               load_bubble = 1'b1;
            end else if (imem_instr == '0) begin
               // Zero word marks end of program and is never forwarded.
               state_next  = S_HALT;
               load_bubble = 1'b1;
            end else begin
               load_fetch  = 1'b1;
               pc_next     = pc + PC_WIDTH'(4);
            end
         end
         S_HALT: begin
            load_bubble = 1'b1;
            if (branch_taken) begin
               pc_next    = branch_target;
               state_next = S_RUN;
            end
         end
         default: begin
            // FAULT: only reset leaves this state.
            load_bubble = 1'b1;
         end
      endcase
   end

   // Outputs decoded from state
   always_comb begin
      halted = (state == S_HALT);
`ifdef FETCH_BOUNDS_CHECK_EN
      fetch_fault = (state == S_FAULT);
`else
      fetch_fault = 1'b0;
`endif
   end

   // PC and IF/ID register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc       <= RESET_PC;
         if_pc    <= '0;
         if_instr <= NOP;
         if_valid <= 1'b0;
      end else begin
         pc <= pc_next;
         if (load_fetch) begin
            if_pc    <= pc;
            if_instr <= imem_instr;
            if_valid <= 1'b1;
         end else if (load_bubble) begin
            if_pc    <= pc;
            if_instr <= NOP;
            if_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit

module tb_fetch_unit;

   localparam logic [31:0] NOP = 32'hD503201F;

`ifdef FETCH_BOUNDS_CHECK_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif

   logic        clk;
   logic        reset;
   logic        stall;
   logic        branch_taken;
   logic [63:0] branch_target;
   logic [63:0] imem_addr;
   logic [31:0] imem_instr;
   logic [63:0] if_pc;
   logic [31:0] if_instr;
   logic        if_valid;
   logic        halted;
   logic        fetch_fault;

   logic [31:0] mem [1024];

   int n_checks = 0;
   int n_fail   = 0;

   assign imem_instr = mem[imem_addr[11:2]];

   fetch_unit dut (
      .clk           (clk),
      .reset         (reset),
      .stall         (stall),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .imem_addr     (imem_addr),
      .imem_instr    (imem_instr),
      .if_pc         (if_pc),
      .if_instr      (if_instr),
      .if_valid      (if_valid),
      .halted        (halted),
      .fetch_fault   (fetch_fault)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: spec rules applied to plain variables.
   logic [63:0] m_pc;
   logic [63:0] m_if_pc;
   logic [31:0] m_if_instr;
   logic        m_if_valid;
   logic        m_halt;
   logic        m_fault;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_pc <= 64'h0; m_if_pc <= 64'h0; m_if_instr <= NOP; m_if_valid <= 1'b0;
         m_halt <= 1'b0; m_fault <= 1'b0;
      end else if (m_fault) begin
         m_if_pc <= m_pc; m_if_instr <= NOP; m_if_valid <= 1'b0;
      end else if (m_halt) begin
         m_if_pc <= m_pc; m_if_instr <= NOP; m_if_valid <= 1'b0;
         if (branch_taken) begin
            m_pc <= branch_target; m_halt <= 1'b0;
         end
      end else if (branch_taken) begin
         m_pc <= branch_target;
         m_if_pc <= m_pc; m_if_instr <= NOP; m_if_valid <= 1'b0;
      end else if (stall) begin
         m_pc <= m_pc;
      end else if (CHK && ((m_pc % 4) != 0 || m_pc >= 64'd4096)) begin
         m_fault <= 1'b1;
         m_if_pc <= m_pc; m_if_instr <= NOP; m_if_valid <= 1'b0;
      end else if (mem[m_pc[11:2]] == 32'h0) begin
         m_halt <= 1'b1;
         m_if_pc <= m_pc; m_if_instr <= NOP; m_if_valid <= 1'b0;
      end else begin
         m_if_pc <= m_pc; m_if_instr <= mem[m_pc[11:2]]; m_if_valid <= 1'b1;
         m_pc <= m_pc + 64'd4;
      end
   end

   // Per-cycle comparison against the model.
   always @(negedge clk) begin
      check("m_imem_addr", imem_addr, m_pc);
      check("m_if_pc", if_pc, m_if_pc);
      check("m_if_instr", {32'h0, if_instr}, {32'h0, m_if_instr});
      check("m_if_valid", {63'h0, if_valid}, {63'h0, m_if_valid});
      check("m_halted", {63'h0, halted}, {63'h0, m_halt});
      check("m_fetch_fault", {63'h0, fetch_fault}, {63'h0, m_fault});
   end

   task automatic tick;
      @(negedge clk);
      #1;
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = 32'h1000 + i;
      mem[0] = 32'h1; mem[1] = 32'h2; mem[2] = 32'h3; mem[3] = 32'h0;
      mem[16] = 32'hA0; mem[17] = 32'h0; mem[1023] = 32'h77;

      reset = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = 64'h0;
      #1 reset = 1'b1;
      #2;
      check("rst_addr", imem_addr, 64'h0);
      check("rst_if_pc", if_pc, 64'h0);
      check("rst_if_instr", {32'h0, if_instr}, {32'h0, NOP});
      check("rst_if_valid", {63'h0, if_valid}, 64'h0);
      check("rst_halted", {63'h0, halted}, 64'h0);
      check("rst_fault", {63'h0, fetch_fault}, 64'h0);
      tick; reset = 1'b0;

      // Sequential fetch
      tick;
      check("f0_pc", if_pc, 64'h0);
      check("f0_instr", {32'h0, if_instr}, 64'h1);
      check("f0_valid", {63'h0, if_valid}, 64'h1);
      tick;
      check("f1_pc", if_pc, 64'h4);
      check("f1_addr", imem_addr, 64'h8);
      stall = 1'b1;

      // Two stalled edges
      for (int i = 0; i < 2; i++) begin
         tick;
         check("stall_addr", imem_addr, 64'h8);
         check("stall_if_pc", if_pc, 64'h4);
         check("stall_instr", {32'h0, if_instr}, 64'h2);
      end
      stall = 1'b0;
      tick;
      check("f2_pc", if_pc, 64'h8);
      check("f2_instr", {32'h0, if_instr}, 64'h3);

      // Zero word at 0xC halts
      tick;
      check("halt_flag", {63'h0, halted}, 64'h1);
      check("halt_valid", {63'h0, if_valid}, 64'h0);
      check("halt_addr", imem_addr, 64'hC);
      tick;
      check("halt_hold_addr", imem_addr, 64'hC);
      branch_taken = 1'b1; branch_target = 64'h0;
      tick;
      branch_taken = 1'b0;
      check("unhalt_flag", {63'h0, halted}, 64'h0);
      check("unhalt_addr", imem_addr, 64'h0);
      tick;
      check("refetch_pc", if_pc, 64'h0);
      check("refetch_instr", {32'h0, if_instr}, 64'h1);
      tick;
      check("refetch_addr", imem_addr, 64'h8);

      // Branch and stall together: branch wins, one bubble
      branch_taken = 1'b1; stall = 1'b1; branch_target = 64'h40;
      tick;
      branch_taken = 1'b0; stall = 1'b0;
      check("br_bubble_valid", {63'h0, if_valid}, 64'h0);
      check("br_bubble_instr", {32'h0, if_instr}, {32'h0, NOP});
      check("br_addr", imem_addr, 64'h40);
      tick;
      check("br_tgt_pc", if_pc, 64'h40);
      check("br_tgt_instr", {32'h0, if_instr}, 64'hA0);
      check("br_tgt_valid", {63'h0, if_valid}, 64'h1);
      tick;
      check("halt2_flag", {63'h0, halted}, 64'h1);
      check("halt2_addr", imem_addr, 64'h44);

      // Misaligned target
      branch_taken = 1'b1; branch_target = 64'h42;
      tick;
      branch_taken = 1'b0;
      check("mis_addr", imem_addr, 64'h42);
      tick;
`ifdef FETCH_BOUNDS_CHECK_EN
      check("mis_fault", {63'h0, fetch_fault}, 64'h1);
      check("mis_halted", {63'h0, halted}, 64'h0);
      check("mis_valid", {63'h0, if_valid}, 64'h0);
      branch_taken = 1'b1; branch_target = 64'h0;
      tick;
      branch_taken = 1'b0;
      tick;
      check("fault_sticky", {63'h0, fetch_fault}, 64'h1);
      check("fault_addr_hold", imem_addr, 64'h42);
`else
      check("mis_pc", if_pc, 64'h42);
      check("mis_instr", {32'h0, if_instr}, 64'hA0);
      check("mis_nofault", {63'h0, fetch_fault}, 64'h0);
      tick;
      check("halt3_flag", {63'h0, halted}, 64'h1);
      // PC wraps past the top of the address space
      branch_taken = 1'b1; branch_target = 64'hFFFF_FFFF_FFFF_FFFC;
      tick;
      branch_taken = 1'b0;
      tick;
      check("wrap_pc", if_pc, 64'hFFFF_FFFF_FFFF_FFFC);
      check("wrap_instr", {32'h0, if_instr}, 64'h77);
      check("wrap_addr", imem_addr, 64'h0);
`endif

      // Asynchronous reset mid-operation
      #2 reset = 1'b1;
      #1;
      check("arst_addr", imem_addr, 64'h0);
      check("arst_valid", {63'h0, if_valid}, 64'h0);
      check("arst_fault", {63'h0, fetch_fault}, 64'h0);
      check("arst_halted", {63'h0, halted}, 64'h0);
      tick;
      reset = 1'b0;

      // Out-of-range target
      branch_taken = 1'b1; branch_target = 64'h1000;
      tick;
      branch_taken = 1'b0;
      tick;
`ifdef FETCH_BOUNDS_CHECK_EN
      check("oor_fault", {63'h0, fetch_fault}, 64'h1);
`else
      check("oor_alias_instr", {32'h0, if_instr}, 64'h1);
      check("oor_alias_pc", if_pc, 64'h1000);
      check("oor_nofault", {63'h0, fetch_fault}, 64'h0);
`endif
      tick;
      tick;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
